// File: rtl/prbs15_checker.sv
// PRBS-15 (x^15 + x^14 + 1) receive checker: self-synchronises a local LFSR,
// declares lock after a clean run, counts bit errors and drops lock on error bursts.
module prbs15_checker #(
  parameter int unsigned LOCK_CNT = 32,
  parameter int unsigned WIN      = 64,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int unsigned MW = $clog2(LOCK_CNT) + 1;
  localparam int unsigned WW = $clog2(WIN) + 1;
  localparam int unsigned EW = $clog2(LOSS_THR) + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           st, st_nx;
  logic [14:0]      sr, sr_nx;
  logic [3:0]       fill, fill_nx;
  logic [MW-1:0]    match, match_nx;
  logic [WW-1:0]    win_bits, win_bits_nx;
  logic [EW-1:0]    win_err, win_err_nx;
  logic [ERR_W-1:0] err_cnt_nx;
  logic             pulse_nx;
  logic             p, e;

  assign p     = sr[14] ^ sr[13];
  assign e     = din ^ p;
  assign state = st;

  always_comb begin
    st_nx       = st;
    sr_nx       = sr;
    fill_nx     = fill;
    match_nx    = match;
    win_bits_nx = win_bits;
    win_err_nx  = win_err;
    err_cnt_nx  = err_cnt;
    pulse_nx    = 1'b0;
    if (din_valid) begin
      case (st)
        HUNT: begin
          sr_nx   = {sr[13:0], din};
          fill_nx = fill + 4'd1;
          if (fill == 4'd14) begin
            st_nx    = SYNC;
            match_nx = '0;
          end
        end
        SYNC: begin
          sr_nx = {sr[13:0], din};
          // An all-zero register predicts zeros forever; never count that as a match.
          if (!e && (sr != '0)) begin
            match_nx = match + MW'(1);
            if (match == MW'(LOCK_CNT - 1)) begin
              st_nx       = LOCKED;
              win_bits_nx = '0;
              win_err_nx  = '0;
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so a flipped bit costs exactly one error.
          sr_nx    = {sr[13:0], p};
          pulse_nx = e;
          if (e && (err_cnt != '1))
            err_cnt_nx = err_cnt + ERR_W'(1);
          if (e && (win_err == EW'(LOSS_THR - 1))) begin
            st_nx       = HUNT;
            fill_nx     = '0;
            match_nx    = '0;
            win_bits_nx = '0;
            win_err_nx  = '0;
          end else if (win_bits == WW'(WIN - 1)) begin
            win_bits_nx = '0;
            win_err_nx  = '0;
          end else begin
            win_bits_nx = win_bits + WW'(1);
            win_err_nx  = win_err + EW'(e);
          end
        end
        default: st_nx = HUNT;
      endcase
    end
    if (clr_err)
      err_cnt_nx = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= HUNT;
      sr        <= '0;
      fill      <= '0;
      match     <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      st        <= st_nx;
      sr        <= sr_nx;
      fill      <= fill_nx;
      match     <= match_nx;
      win_bits  <= win_bits_nx;
      win_err   <= win_err_nx;
      err_cnt   <= err_cnt_nx;
      err_pulse <= pulse_nx;
      locked    <= (st_nx == LOCKED);
    end
  end

endmodule

// File: doc/prbs15_checker.md
Name: prbs15_checker

Overview:
- Receive-side counterpart to the PRBS generator and pattern-detector path.
- Takes a serial bitstream carrying PRBS-15 (x^15 + x^14 + 1) and self-synchronises a local LFSR to it.
- Declares lock after a run of clean bits, then counts bit errors.
- Drops lock when the error density in a sliding-block window exceeds a threshold. Sits at the link sink for BER measurement.

Parameters:
- LOCK_CNT, 32: consecutive predicted-bit matches in SYNC required to enter LOCKED.
- WIN, 64: window length in valid bits for loss-of-lock evaluation.
- LOSS_THR, 8: errors within one window that force loss of lock.
- ERR_W, 16: width of the saturating error counter.

Ports:
- CLK, input, 1: single clock, rising edge.
- RST, input, 1: asynchronous, active-low reset.
- din_valid, input, 1: din is sampled only when high.
- din, input, 1: received serial bit.
- clr_err, input, 1: synchronous clear of err_cnt.
- locked, output, 1: registered; high while in LOCKED.
- err_pulse, output, 1: registered; one-cycle pulse per errored bit while locked.
- err_cnt, output, ERR_W: registered saturating error count.
- state, output, 2: HUNT=0, SYNC=1, LOCKED=2 (debug).

Behaviour:
- Reset (RST=0, async): sr[14:0]=0, fill=0, match=0, win_bits=0, win_err=0, state=HUNT, locked=0, err_pulse=0, err_cnt=0.
- Prediction: p = sr[14] ^ sr[13]. Mismatch e = din ^ p.
- All state, counters and sr advance only on din_valid=1. With din_valid=0, everything holds except err_pulse, which returns to 0.
- HUNT:
  - sr <= {sr[13:0], din}; fill++.
  - On the valid bit that makes fill==15: go to SYNC with match=0.
- SYNC:
  - sr <= {sr[13:0], din}.
  - e=0 and sr!=0 (pre-shift): match++.
  - e=1, or sr==0: match <= 0. This is the zero-lock guard; an all-zero stream never locks.
  - On the valid bit that makes match==LOCK_CNT: go to LOCKED, with win_bits=0 and win_err=0.
- LOCKED:
  - Flywheel: sr <= {sr[13:0], p}. Received bits no longer load the LFSR, so one flipped bit counts as exactly one error.
  - On e=1: err_pulse=1 next cycle; err_cnt++, saturating at 2^ERR_W-1; win_err++.
  - win_bits++ each valid bit. When win_bits reaches WIN, both win_bits and win_err reset to 0, unless loss triggers on the same bit.
  - When an error makes win_err==LOSS_THR: go to HUNT with fill=0 and match=0. err_cnt still includes that error.
- locked is registered from next-state: it rises in the cycle after the completing valid bit and falls in the cycle after the LOSS_THR-th error.
- clr_err=1 sets err_cnt=0 next cycle. clr_err has priority over a coincident increment (result 0); err_pulse is still issued. clr_err does not affect state or window counters.
- err_cnt is held (not cleared) across lock loss and re-lock.
- Counters are sized for LOCK_CNT and WIN (clog2+1). Wrap-around never occurs because counters reset at their terminal values.
- A RST assertion mid-stream immediately returns all outputs to reset values. After release, a full HUNT of 15 bits plus a SYNC of LOCK_CNT bits is required.

Test Plan:
- Reset: hold RST=0 while toggling din and din_valid -> locked=0, err_pulse=0, err_cnt=0, state=0 throughout. Deassert RST -> state stays 0 until valid bits arrive.
- Clean lock: PRBS-15 from seed 0x7FFF, din_valid=1 every cycle -> state=1 after bit 15. locked=1 in the cycle after valid bit 47 (15+32). err_cnt stays 0 over 10000 bits.
- Single error after lock: invert bit 200 -> exactly one err_pulse, one cycle after bit 200. err_cnt=1 and locked stays 1.
- Loss of lock: invert 8 bits within one 64-bit window -> locked falls after the 8th error and err_cnt=8. Resume a clean stream -> locked rises again 47 valid bits later, with err_cnt still 8. Inverting 7 bits per window repeatedly -> lock is retained.
- Zero-lock guard: din=0 for 500 valid bits -> never locked; state stays 1.
- Gaps and clear:
  - Insert random din_valid=0 gaps into the clean stream -> lock timing counts valid bits only.
  - clr_err coincident with an error -> err_cnt=0 and err_pulse=1.
  - Preload 2^ERR_W-1 errors -> err_cnt saturates at 0xFFFF.
